spi_burst_arbiter: RTL and testbench

Shares the SoC's single SPI byte-transfer engine between two requesters: port 0 is the CPU MMIO SPI register block, port 1 is an auxiliary poller. It owns `spi_cs`. It grants whole bursts, never single bytes, so a burst is never interleaved. It also enforces CS setup, hold and gap timing around each burst, and aborts a stalled burst by timeout. It sits between the requesters and the shift engine, which drives `spi_sclk`, `spi_mosi` and samples `spi_miso`.

---
 rtl/spi_burst_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_burst_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_arbiter.sv
// Burst-granular arbiter sharing one SPI byte engine between two requesters.
// Owns spi_cs and enforces CS setup/hold/gap timing plus a stall timeout.
module spi_burst_arbiter #(
    parameter int CS_SETUP     = 4,
    parameter int CS_HOLD      = 4,
    parameter int CS_GAP       = 8,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] last,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    output logic [1:0] grant,
    output logic [1:0] ack,
    output logic [1:0] abort,
    output logic [7:0] rx_data,
    output logic       eng_start,
    output logic [7:0] eng_tx,
    input  logic       eng_done,
    input  logic [7:0] eng_rx,
    output logic       spi_cs
);

    localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
    localparam logic [15:0] GAP_END   = 16'(CS_GAP - 1);
    localparam logic [15:0] TO_PRE    = 16'(IDLE_TIMEOUT - 1);
    localparam logic [15:0] TO_END    = 16'(IDLE_TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, SETUP, START, WAIT, ACK, NEXT, HOLD, GAP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  abort_q, abort_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  tx_q, tx_d;
    logic        start_q, start_d;
    logic        last_q, last_d;
    logic        cs_q, cs_d;
    logic        ptr_q, ptr_d;
    logic        launch;
    logic        req_g;
    logic        last_g;
    logic [7:0]  tx_g;

    assign req_g  = |(req & grant_q);
    assign last_g = |(last & grant_q);
    assign tx_g   = grant_q[1] ? tx1 : tx0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        ack_d   = 2'b00;
        abort_d = 2'b00;
        rx_d    = rx_q;
        tx_d    = tx_q;
        start_d = 1'b0;
        last_d  = last_q;
        cs_d    = cs_q;
        ptr_d   = ptr_q;
        launch  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = SETUP;
                    cs_d    = 1'b0;
                    cnt_d   = '0;
                    if (req == 2'b11) grant_d = ptr_q ? 2'b10 : 2'b01;
                    else              grant_d = req;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_END) launch = 1'b1;
                else                    cnt_d  = cnt_q + 16'd1;
            end
            START: state_d = WAIT;
            WAIT: begin
                if (eng_done) begin
                    rx_d    = eng_rx;
                    ack_d   = grant_q;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = last_q ? HOLD : NEXT;
                cnt_d   = '0;
            end
            NEXT: begin
                // abort is already visible in the cycle the count lands
                if (cnt_q == TO_END) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (req_g) begin
                    launch = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == TO_PRE) abort_d = grant_q;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_END) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    grant_d = 2'b00;
                    ptr_d   = grant_q[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_END) state_d = IDLE;
                else                  cnt_d   = cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            state_d = START;
            start_d = 1'b1;
            tx_d    = tx_g;
            last_d  = last_g;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 2'b00;
            ack_q   <= 2'b00;
            abort_q <= 2'b00;
            rx_q    <= 8'h00;
            tx_q    <= 8'h00;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            cs_q    <= 1'b1;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            abort_q <= abort_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            start_q <= start_d;
            last_q  <= last_d;
            cs_q    <= cs_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign ack       = ack_q;
    assign abort     = abort_q;
    assign rx_data   = rx_q;
    assign eng_start = start_q;
    assign eng_tx    = tx_q;
    assign spi_cs    = cs_q;

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Bench for spi_burst_arbiter: engine model, requester queues, event logs,
// burst vector table, directed corner cases and randomized bursts.
module tb_spi_burst_arbiter;

    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int CS_GAP   = 8;
    localparam int TO       = 16;
    localparam int ENG_LAT  = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] last = 2'b00;
    logic [7:0] tx0 = 8'h00;
    logic [7:0] tx1 = 8'h00;
    logic [1:0] grant, ack, abort;
    logic [7:0] rx_data, eng_tx;
    logic       eng_start, spi_cs;
    logic       eng_done;
    logic [7:0] eng_rx = 8'h00;
    logic       done_m = 1'b0;
    logic       stray = 1'b0;

    assign eng_done = done_m | stray;

    spi_burst_arbiter #(
        .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
        .CS_GAP(CS_GAP), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last),
        .tx0(tx0), .tx1(tx1), .grant(grant), .ack(ack),
        .abort(abort), .rx_data(rx_data), .eng_start(eng_start),
        .eng_tx(eng_tx), .eng_done(eng_done), .eng_rx(eng_rx),
        .spi_cs(spi_cs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       lst;
        int         gap;
    } byte_t;

    byte_t q0[$];
    byte_t q1[$];

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;

    int log_gcyc[$], log_gval[$], log_start[$], log_ack[$], log_rx[$];
    int log_csfall[$], log_csrise[$], log_abort[$], log_abortv[$];

    function automatic void chk(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic int at(input int q[$], input int i);
        if (i < 0 || i >= q.size()) return -9999;
        return q[i];
    endfunction

    function automatic int qsize(int r);
        return (r == 0) ? q0.size() : q1.size();
    endfunction

    function automatic byte_t qhead(int r);
        return (r == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpop(int r);
        if (r == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic void qpush(int r, byte_t b);
        if (r == 0) q0.push_back(b);
        else        q1.push_back(b);
    endfunction

    function automatic void clear_logs();
        log_gcyc.delete();   log_gval.delete();  log_start.delete();
        log_ack.delete();    log_rx.delete();    log_csfall.delete();
        log_csrise.delete(); log_abort.delete(); log_abortv.delete();
    endfunction

    // engine model and monitor state
    int         eng_tmr = 0;
    logic [7:0] eng_pend = 8'h00;
    logic       done_prev = 1'b0;
    logic       outstanding = 1'b0;
    logic [1:0] grant_prev = 2'b00;
    logic       cs_prev = 1'b1;
    logic       fav = 1'b0;
    logic       aborted = 1'b0;
    logic       first_start = 1'b0;
    logic       both_seen = 1'b0;
    int         grise_c = -1000;
    int         csrise_c = -1000;
    int         lastack_c = -1000;
    int         abort_c = -1000;
    int         wait_c[2] = '{0, 0};

    task automatic monitor();
        byte_t      h;
        int         r;
        logic [1:0] exp_g;
        logic [7:0] exp_rx;
        if (!rst_n) begin
            outstanding = 1'b0; done_prev = 1'b0; fav = 1'b0;
            grant_prev = 2'b00; cs_prev = 1'b1; csrise_c = -1000;
            return;
        end
        chk("cs_vs_grant", int'(spi_cs), int'(grant == 2'b00));
        if (grant == 2'b11) both_seen = 1'b1;
        chk("ack_timing", int'(ack),
            (done_prev && outstanding) ? int'(grant) : 0);
        if (grant != 2'b00 && grant_prev == 2'b00) begin
            exp_g = (req == 2'b11) ? (fav ? 2'b10 : 2'b01) : req;
            chk("grant_pick", int'(grant), int'(exp_g));
            chk("cs_gap_min", int'((cyc - csrise_c) >= CS_GAP + 1), 1);
            grise_c = cyc; aborted = 1'b0; first_start = 1'b1;
            log_gcyc.push_back(cyc); log_gval.push_back(int'(grant));
        end
        if (grant == 2'b00 && grant_prev != 2'b00) fav = grant_prev[0];
        if (spi_cs && !cs_prev) begin
            chk("cs_hold", cyc - (aborted ? abort_c : lastack_c), 1 + CS_HOLD);
            csrise_c = cyc; log_csrise.push_back(cyc);
        end
        if (!spi_cs && cs_prev) log_csfall.push_back(cyc);
        if (eng_start) begin
            r = grant[1] ? 1 : 0;
            if (first_start) chk("cs_setup", cyc - grise_c, CS_SETUP);
            first_start = 1'b0;
            if (qsize(r) == 0) chk("start_without_byte", 0, 1);
            else begin
                h = qhead(r);
                chk("eng_tx", int'(eng_tx), int'(h.data));
            end
            outstanding = 1'b1; log_start.push_back(cyc);
        end
        if (ack != 2'b00) begin
            r = ack[1] ? 1 : 0;
            outstanding = 1'b0;
            if (qsize(r) == 0) chk("ack_without_byte", 0, 1);
            else begin
                h = qhead(r);
                exp_rx = h.data + 8'd1;
                chk("rx_data", int'(rx_data), int'(exp_rx));
                if (h.lst) lastack_c = cyc;
            end
            log_ack.push_back(cyc); log_rx.push_back(int'(rx_data));
        end
        if (abort != 2'b00) begin
            chk("abort_owner", int'(abort), int'(grant));
            abort_c = cyc; aborted = 1'b1;
            log_abort.push_back(cyc); log_abortv.push_back(int'(abort));
        end
        done_prev  = done_m | stray;
        grant_prev = grant;
        cs_prev    = spi_cs;
    endtask

    task automatic drive();
        byte_t h;
        for (int r = 0; r < 2; r++) begin
            if (!rst_n) begin
                wait_c[r] = 0; req[r] = 1'b0;
            end else begin
                if (ack[r] && qsize(r) > 0) begin
                    qpop(r);
                    if (qsize(r) > 0) begin h = qhead(r); wait_c[r] = h.gap; end
                end
                // a killed burst is abandoned by its requester
                if (abort[r]) begin
                    while (qsize(r) > 0) begin
                        h = qhead(r); qpop(r);
                        if (h.lst) break;
                    end
                    wait_c[r] = 0;
                end
                if (wait_c[r] > 0) begin req[r] = 1'b0; wait_c[r]--; end
                else req[r] = (qsize(r) > 0);
                if (qsize(r) > 0) begin
                    h = qhead(r); last[r] = h.lst;
                    if (r == 0) tx0 = h.data; else tx1 = h.data;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        done_m = 1'b0;
        if (!rst_n) eng_tmr = 0;
        else if (eng_start) begin
            eng_tmr = ENG_LAT; eng_pend = eng_tx + 8'd1;
        end else if (eng_tmr > 0) begin
            eng_tmr--;
            if (eng_tmr == 0) begin done_m = 1'b1; eng_rx = eng_pend; end
        end
        monitor();
        drive();
    end

    task automatic push_burst(int r, int n, logic [7:0] base,
                              logic [7:0] step, int gf, int gi);
        byte_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + 8'(i) * step;
            b.lst  = (i == n - 1);
            b.gap  = (i == 0) ? gf : gi;
            qpush(r, b);
        end
    endtask

    task automatic wait_quiet(int budget);
        int quiet = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (q0.size() == 0 && q1.size() == 0 && grant == 2'b00 && spi_cs)
                quiet++;
            else quiet = 0;
            if (quiet >= CS_GAP + 2) return;
        end
        chk("wait_quiet_timeout", 0, 1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_cs", int'(spi_cs), 1);
        chk("rst_grant", int'(grant), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_abort", int'(abort), 0);
        chk("rst_start", int'(eng_start), 0);
        chk("rst_eng_tx", int'(eng_tx), 0);
        chk("rst_rx", int'(rx_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int         who;
        int         nbytes;
        logic [7:0] base;
        logic [7:0] step;
        int         exp_grant;
        int         exp_setup;
        int         exp_space;
        int         exp_hold;
        int         exp_rx_last;
    } vec_t;

    vec_t vt[4];
    int   total;
    int   n;
    byte_t rb;

    initial begin
        vt[0] = '{0, 1, 8'h00, 8'h00, 1, CS_SETUP, 0, 1 + CS_HOLD, 8'h01};
        vt[1] = '{1, 3, 8'h10, 8'h10, 2, CS_SETUP, ENG_LAT + 3, 1 + CS_HOLD, 8'h31};
        vt[2] = '{0, 2, 8'hFF, 8'h01, 1, CS_SETUP, ENG_LAT + 3, 1 + CS_HOLD, 8'h01};
        vt[3] = '{1, 4, 8'h7E, 8'h01, 2, CS_SETUP, ENG_LAT + 3, 1 + CS_HOLD, 8'h82};

        #2;
        apply_reset();

        for (int v = 0; v < 4; v++) begin
            clear_logs();
            push_burst(vt[v].who, vt[v].nbytes, vt[v].base, vt[v].step, 0, 0);
            wait_quiet(3000);
            chk("v_grant", at(log_gval, 0), vt[v].exp_grant);
            chk("v_setup", at(log_start, 0) - at(log_gcyc, 0), vt[v].exp_setup);
            chk("v_cs_fall", at(log_csfall, 0) - at(log_gcyc, 0), 0);
            chk("v_windows", log_csfall.size(), 1);
            chk("v_nstart", log_start.size(), vt[v].nbytes);
            for (int i = 1; i < vt[v].nbytes; i++)
                chk("v_spacing", at(log_start, i) - at(log_start, i - 1),
                    vt[v].exp_space);
            chk("v_rx_last", at(log_rx, vt[v].nbytes - 1), vt[v].exp_rx_last);
            chk("v_hold", at(log_csrise, 0) - at(log_ack, vt[v].nbytes - 1),
                vt[v].exp_hold);
            chk("v_grant_end", int'(grant), 0);
        end

        // simultaneous requests straight after reset
        apply_reset();
        clear_logs();
        both_seen = 1'b0;
        push_burst(0, 2, 8'hA1, 8'h01, 0, 0);
        push_burst(1, 2, 8'hB1, 8'h01, 0, 0);
        wait_quiet(3000);
        chk("sim_first", at(log_gval, 0), 1);
        chk("sim_second", at(log_gval, 1), 2);
        chk("sim_regrant", at(log_gcyc, 1) - at(log_ack, 1),
            2 + CS_HOLD + CS_GAP);
        chk("sim_never_both", int'(both_seen), 0);

        // stall timeout after a non-last byte
        clear_logs();
        rb.data = 8'h55; rb.lst = 1'b0; rb.gap = 0;
        qpush(0, rb);
        wait_quiet(3000);
        chk("to_nabort", log_abort.size(), 1);
        chk("to_abort_val", at(log_abortv, 0), 1);
        chk("to_abort_time", at(log_abort, 0) - at(log_ack, 0), TO + 1);
        chk("to_cs_rise", at(log_csrise, 0) - at(log_abort, 0), 1 + CS_HOLD);
        chk("to_nstart", log_start.size(), 1);

        // reset in the middle of WAIT, then a stray eng_done
        clear_logs();
        push_burst(0, 2, 8'hC0, 8'h01, 0, 0);
        for (int i = 0; i < 100 && log_start.size() == 0; i++) @(posedge clk);
        chk("rst_mid_started", log_start.size(), 1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cs", int'(spi_cs), 1);
        chk("rst_mid_grant", int'(grant), 0);
        q0.delete(); q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        @(posedge clk); stray = 1'b1;
        @(posedge clk); stray = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("stray_no_ack", log_ack.size(), 0);
        chk("stray_grant", int'(grant), 0);
        chk("stray_no_start", log_start.size(), 0);

        // round-robin with both requesters always busy
        apply_reset();
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            push_burst(0, 1, 8'h40 + 8'(i), 8'h00, 0, 0);
            push_burst(1, 1, 8'hE0 + 8'(i), 8'h00, 0, 0);
        end
        wait_quiet(5000);
        chk("rr_count", log_gval.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("rr_order", at(log_gval, i), (i % 2 == 0) ? 1 : 2);

        // randomized bursts with short in-burst stalls
        clear_logs();
        both_seen = 1'b0;
        total = 0;
        for (int b = 0; b < 16; b++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                rb.data = 8'($urandom);
                rb.lst  = (i == n - 1);
                rb.gap  = (i == 0) ? $urandom_range(0, 20)
                                   : (($urandom_range(0, 3) == 0)
                                      ? $urandom_range(1, TO - 6) : 0);
                qpush(b % 2, rb);
            end
            total += n;
        end
        wait_quiet(20000);
        chk("rand_acks", log_ack.size(), total);
        chk("rand_starts", log_start.size(), total);
        chk("rand_no_abort", log_abort.size(), 0);
        chk("rand_never_both", int'(both_seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
